// File: rtl/grf_scoreboard.sv
// General register file with N_RD combinational read ports, same-cycle write-to-read bypass
// and a per-register pending-write scoreboard for the decode-stage hazard unit.
module grf_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned N_RD     = 2,
    parameter int unsigned CNT_W    = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     wb_err
);

    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt  [DEPTH];

    logic wb_zero;
    logic iss_zero;
    logic wb_en;
    logic wb_pending;
    logic dec_en;
    logic inc_en;
    logic same_reg;

    // Write-back and bypass are masked while reset is low so outputs read as cleared.
    assign wb_zero    = ZERO_REG && (wb_addr == '0);
    assign iss_zero   = ZERO_REG && (iss_addr == '0);
    assign wb_en      = wb_valid && reset && !wb_zero;
    assign wb_pending = (cnt[wb_addr] != '0);
    assign dec_en     = wb_en && wb_pending;
    assign same_reg   = (wb_addr == iss_addr);

    assign iss_ready  = iss_zero || (cnt[iss_addr] != CNT_MAX) || (dec_en && same_reg);
    assign inc_en     = iss_valid && iss_ready && !iss_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            wb_err <= 1'b0;
        end else begin
            if (wb_en)
                regs[wb_addr] <= wb_data;
            // An increment and decrement on the same register cancel out.
            if (inc_en && !(dec_en && same_reg))
                cnt[iss_addr] <= cnt[iss_addr] + CNT_W'(1);
            if (dec_en && !(inc_en && same_reg))
                cnt[wb_addr] <= cnt[wb_addr] - CNT_W'(1);
            if (wb_en && !wb_pending)
                wb_err <= 1'b1;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              dec_a;
        logic [CNT_W-1:0]  left;
        rd_data = '0;
        rd_busy = '0;
        a       = '0;
        dec_a   = 1'b0;
        left    = '0;
        for (int unsigned i = 0; i < N_RD; i++) begin
            a     = rd_addr[i*ADDR_W +: ADDR_W];
            dec_a = dec_en && (wb_addr == a);
            left  = cnt[a] - CNT_W'(dec_a);
            if (ZERO_REG && (a == '0))
                rd_data[i*DATA_W +: DATA_W] = '0;
            else if (wb_en && (wb_addr == a))
                rd_data[i*DATA_W +: DATA_W] = wb_data;
            else
                rd_data[i*DATA_W +: DATA_W] = regs[a];
            rd_busy[i] = (left != '0);
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomized bench for grf_scoreboard against a register-file/scoreboard reference model.
module tb_grf_scoreboard;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic              iss_ready;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              wb_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;

    grf_scoreboard #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .N_RD    (NR),
        .CNT_W   (CW),
        .ZERO_REG(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_valid(iss_valid),
        .iss_addr (iss_addr),
        .iss_ready(iss_ready),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic bit m_dec(input int r, input bit wv, input int wa);
        return wv && (wa == r) && (r != 0) && (m_cnt[r] > 0);
    endfunction

    // Drive one cycle of stimulus, check the combinational outputs mid-cycle, then advance the model.
    task automatic step(input int a0, input int a1, input bit iv, input int ia,
                        input bit wv, input int wa, input logic [31:0] wd);
        int          ra [2];
        logic [31:0] ed;
        int          left;
        bit          rdy;
        bit          dd;
        logic [4:0]  x0;
        logic [4:0]  x1;
        x0 = a0[4:0];
        x1 = a1[4:0];
        rd_addr   = {x1, x0};
        iss_valid = iv;
        iss_addr  = ia[4:0];
        wb_valid  = wv;
        wb_addr   = wa[4:0];
        wb_data   = wd;
        #1;
        ra[0] = a0;
        ra[1] = a1;
        for (int p = 0; p < 2; p++) begin
            if (!reset || ra[p] == 0)
                ed = '0;
            else if (wv && wa == ra[p])
                ed = wd;
            else
                ed = m_regs[ra[p]];
            check($sformatf("rd_data%0d@r%0d", p, ra[p]), rd_data[p*32 +: 32], ed);
            left = m_cnt[ra[p]] - ((reset && m_dec(ra[p], wv, wa)) ? 1 : 0);
            check($sformatf("rd_busy%0d@r%0d", p, ra[p]), 32'(rd_busy[p]), 32'(left != 0));
        end
        rdy = (ia == 0) || (m_cnt[ia] < CMAX) || (reset && m_dec(ia, wv, wa));
        check($sformatf("iss_ready@r%0d", ia), 32'(iss_ready), 32'(rdy));
        check("wb_err", 32'(wb_err), 32'(m_err));
        @(posedge clk);
        if (reset) begin
            dd = m_dec(wa, wv, wa);
            if (wv && wa != 0) begin
                m_regs[wa] = wd;
                if (m_cnt[wa] == 0)
                    m_err = 1'b1;
            end
            if (dd)
                m_cnt[wa]--;
            if (iv && rdy && ia != 0)
                m_cnt[ia]++;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
    task automatic pulse_reset(input int a0, input int a1);
        logic [4:0] x0;
        logic [4:0] x1;
        x0 = a0[4:0];
        x1 = a1[4:0];
        rd_addr   = {x1, x0};
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        #1 reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_data0", rd_data[31:0], 32'h0);
        check("async_rst_data1", rd_data[63:32], 32'h0);
        check("async_rst_busy", 32'(rd_busy), 32'h0);
        check("async_rst_ready", 32'(iss_ready), 32'h1);
        check("async_rst_err", 32'(wb_err), 32'h0);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 3) != 0)
            return int'($urandom_range(0, 7));
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        reset     = 1'b0;
        rd_addr   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Write and claim during reset are discarded.
        step(6, 6, 1'b1, 6, 1'b1, 6, 32'hDEADBEEF);
        reset = 1'b1;

        for (int i = 0; i < 32; i++)
            step(i, 31 - i, 1'b0, i, 1'b0, 0, 32'h0);

        // Bypass then registered read.
        step(5, 5, 1'b0, 0, 1'b1, 5, 32'h12345678);
        step(5, 0, 1'b0, 0, 1'b0, 0, 32'h0);
        check("r5_after_write", rd_data[31:0], 32'h12345678);

        // Register 0 is protected.
        step(0, 0, 1'b0, 0, 1'b1, 0, 32'hFFFFFFFF);
        step(0, 0, 1'b1, 0, 1'b0, 0, 32'h0);
        step(0, 0, 1'b0, 0, 1'b0, 0, 32'h0);

        // Saturate register 7, reject, accept with concurrent write-back, then drain.
        repeat (3) step(7, 7, 1'b1, 7, 1'b0, 0, 32'h0);
        step(7, 7, 1'b1, 7, 1'b0, 0, 32'h0);
        step(7, 7, 1'b1, 7, 1'b1, 7, 32'h00000071);
        for (int k = 0; k < 3; k++)
            step(7, 7, 1'b0, 7, 1'b1, 7, 32'h00000072 + k);
        step(7, 7, 1'b0, 7, 1'b0, 0, 32'h0);
        check("r7_idle_busy", 32'(rd_busy), 32'h0);

        // Underflow write-back.
        step(9, 9, 1'b0, 0, 1'b1, 9, 32'hA5A5A5A5);
        step(9, 9, 1'b0, 0, 1'b0, 0, 32'h0);
        check("wb_err_sticky", 32'(wb_err), 32'h1);
        step(9, 1, 1'b0, 0, 1'b0, 0, 32'h0);

        // Claims then asynchronous reset.
        step(3, 4, 1'b1, 3, 1'b0, 0, 32'h0);
        step(3, 4, 1'b1, 4, 1'b1, 3, 32'h33333333);
        step(3, 4, 1'b0, 0, 1'b1, 4, 32'h44444444);
        step(3, 4, 1'b1, 3, 1'b0, 0, 32'h0);
        step(3, 4, 1'b1, 4, 1'b0, 0, 32'h0);
        pulse_reset(3, 4);
        step(3, 4, 1'b0, 0, 1'b0, 0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999)
                pulse_reset(pick_addr(), pick_addr());
            step(pick_addr(), pick_addr(),
                 1'($urandom_range(0, 1)), pick_addr(),
                 1'($urandom_range(0, 1)), pick_addr(), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
